// File: rtl/fan_ctrl_multi.sv
// Multi-channel PWM fan controller: prescaled PWM, soft-start duty ramp,
// windowed tachometer counting with stall detection.
module fan_ctrl_multi #(
  parameter int NumCh       = 2,
  parameter int CntWidth    = 8,
  parameter int PrescDiv    = 50,
  parameter int RampPeriods = 4,
  parameter int TachWindow  = 1000,
  parameter int TachWidth   = 16
) (
  input  logic                          soc_clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic [NumCh*CntWidth-1:0]     duty_i,
  input  logic                          force_full_i,
  input  logic [NumCh-1:0]              tach_i,
  output logic [NumCh-1:0]              fan_pwm_o,
  output logic [NumCh*CntWidth-1:0]     cur_duty_o,
  output logic [NumCh*TachWidth-1:0]    tach_cnt_o,
  output logic                          tach_valid_o,
  output logic [NumCh-1:0]              stall_o
);

  localparam int PW = $clog2(PrescDiv + 1);
  localparam int RW = $clog2(RampPeriods + 1);
  localparam int WW = $clog2(TachWindow + 1);

  localparam logic [PW-1:0] PrescMax = PW'(PrescDiv - 1);
  localparam logic [RW-1:0] RampMax  = RW'(RampPeriods - 1);
  localparam logic [WW-1:0] WinMax   = WW'(TachWindow - 1);
  localparam logic [CntWidth-1:0]  DutyMax = '1;
  localparam logic [TachWidth-1:0] TachMax = '1;

  logic [PW-1:0]       presc_q, presc_d;
  logic [CntWidth-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [RW-1:0]       ramp_q, ramp_d;
  logic [WW-1:0]       win_q, win_d;

  logic [NumCh-1:0][CntWidth-1:0]  duty_q, duty_d;
  logic [NumCh-1:0][CntWidth-1:0]  tgt;
  logic [NumCh-1:0][TachWidth-1:0] acc_q, acc_d;
  logic [NumCh-1:0][TachWidth-1:0] sum;
  logic [NumCh-1:0][TachWidth-1:0] tcnt_q, tcnt_d;

  logic [NumCh-1:0] pwm_q, pwm_d;
  logic [NumCh-1:0] stall_q, stall_d;
  logic             valid_q, valid_d;
  logic [NumCh-1:0] sync1_q, sync2_q, sync3_q;
  logic [NumCh-1:0] edge_v;

  logic tick, wrap, step, win_end;

  assign tick    = (presc_q == PrescMax);
  assign wrap    = tick && (pwm_cnt_q == DutyMax);
  assign step    = wrap && (ramp_q == RampMax);
  assign win_end = tick && (win_q == WinMax);
  assign edge_v  = sync2_q & ~sync3_q;

  // sum includes an edge landing on the window-end cycle
  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    assign tgt[c] = duty_i[c*CntWidth +: CntWidth];
    assign sum[c] = (edge_v[c] && acc_q[c] != TachMax)
                  ? acc_q[c] + TachWidth'(1) : acc_q[c];
  end

  always_comb begin
    presc_d   = tick ? '0 : presc_q + PW'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + CntWidth'(1) : pwm_cnt_q;
    ramp_d    = ramp_q;
    win_d     = win_q;
    duty_d    = duty_q;
    acc_d     = acc_q;
    tcnt_d    = tcnt_q;
    pwm_d     = '0;
    stall_d   = stall_q;
    valid_d   = win_end;

    if (wrap && !force_full_i)
      ramp_d = step ? '0 : ramp_q + RW'(1);

    if (win_end)   win_d = '0;
    else if (tick) win_d = win_q + WW'(1);

    for (int c = 0; c < NumCh; c++) begin
      pwm_d[c] = (pwm_cnt_q < duty_q[c]) ||
                 (duty_q[c] == DutyMax) || force_full_i;
      if (force_full_i)
        duty_d[c] = DutyMax;
      else if (step && duty_q[c] < tgt[c])
        duty_d[c] = duty_q[c] + CntWidth'(1);
      else if (step && duty_q[c] > tgt[c])
        duty_d[c] = duty_q[c] - CntWidth'(1);

      acc_d[c] = win_end ? '0 : sum[c];
      if (win_end) begin
        tcnt_d[c]  = sum[c];
        stall_d[c] = (sum[c] == '0) &&
                     (duty_q[c] != '0 || force_full_i);
      end
    end

    // disable clears everything except the last window result
    if (!en_i) begin
      presc_d   = '0;
      pwm_cnt_d = '0;
      ramp_d    = '0;
      win_d     = '0;
      duty_d    = '0;
      acc_d     = '0;
      tcnt_d    = tcnt_q;
      pwm_d     = '0;
      stall_d   = '0;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      ramp_q    <= '0;
      win_q     <= '0;
      duty_q    <= '0;
      acc_q     <= '0;
      tcnt_q    <= '0;
      pwm_q     <= '0;
      stall_q   <= '0;
      valid_q   <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      sync3_q   <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      ramp_q    <= ramp_d;
      win_q     <= win_d;
      duty_q    <= duty_d;
      acc_q     <= acc_d;
      tcnt_q    <= tcnt_d;
      pwm_q     <= pwm_d;
      stall_q   <= stall_d;
      valid_q   <= valid_d;
      sync1_q   <= tach_i;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
    end
  end

  assign fan_pwm_o    = pwm_q;
  assign cur_duty_o   = duty_q;
  assign tach_cnt_o   = tcnt_q;
  assign tach_valid_o = valid_q;
  assign stall_o      = stall_q;

endmodule

// File: tb/tb_fan_ctrl_multi.sv
// Directed bench for fan_ctrl_multi: ramp, PWM, force, tach, stall,
// disable/reset and counter saturation (second, narrow-tach instance).
module tb_fan_ctrl_multi;

  logic        soc_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b1;
  logic        force_full_i = 1'b0;
  logic [7:0]  duty_i = 8'h08;
  logic [1:0]  tach_i = 2'b00;
  logic [1:0]  tach_s = 2'b00;

  logic [1:0]  fan_pwm_o, stall_o;
  logic [7:0]  cur_duty_o;
  logic [31:0] tach_cnt_o;
  logic        tach_valid_o;

  logic [1:0]  s_pwm, s_stall;
  logic [7:0]  s_duty;
  logic [3:0]  s_cnt;
  logic        s_valid;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int hi0, hi1;

  always #5 soc_clk = ~soc_clk;

  fan_ctrl_multi #(
    .NumCh(2), .CntWidth(4), .PrescDiv(2),
    .RampPeriods(1), .TachWindow(8), .TachWidth(16)
  ) u_dut (
    .soc_clk(soc_clk), .rst_n(rst_n), .en_i(en_i),
    .duty_i(duty_i), .force_full_i(force_full_i),
    .tach_i(tach_i), .fan_pwm_o(fan_pwm_o),
    .cur_duty_o(cur_duty_o), .tach_cnt_o(tach_cnt_o),
    .tach_valid_o(tach_valid_o), .stall_o(stall_o)
  );

  fan_ctrl_multi #(
    .NumCh(2), .CntWidth(4), .PrescDiv(2),
    .RampPeriods(1), .TachWindow(8), .TachWidth(2)
  ) u_sat (
    .soc_clk(soc_clk), .rst_n(rst_n), .en_i(en_i),
    .duty_i(duty_i), .force_full_i(force_full_i),
    .tach_i(tach_s), .fan_pwm_o(s_pwm),
    .cur_duty_o(s_duty), .tach_cnt_o(s_cnt),
    .tach_valid_o(s_valid), .stall_o(s_stall)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h exp %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic tick1();
    @(negedge soc_clk);
    cyc++;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick1();
  endtask

  task automatic pulse(input int t);
    wait_to(t);
    tach_i[1] = 1'b1;
    wait_to(t + 2);
    tach_i[1] = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge soc_clk);
    chk("rst_duty", cur_duty_o, 8'h00);
    chk("rst_pwm", fan_pwm_o, 2'b00);
    chk("rst_tcnt", tach_cnt_o, 32'h0);
    chk("rst_valid", tach_valid_o, 1'b0);
    chk("rst_stall", stall_o, 2'b00);
    rst_n = 1'b1;
    cyc = 0;

    // soft start ch0 -> 8, ch1 held at 0
    wait_to(31);  chk("ramp_31", cur_duty_o, 8'h00);
    wait_to(32);  chk("ramp_32", cur_duty_o, 8'h01);
    wait_to(64);  chk("ramp_64", cur_duty_o, 8'h02);
    wait_to(255); chk("ramp_255", cur_duty_o, 8'h07);
    wait_to(256); chk("ramp_256", cur_duty_o, 8'h08);
    chk("stall_a", stall_o, 2'b01);
    hi0 = 0; hi1 = 0;
    for (int i = 0; i < 32; i++) begin
      tick1();
      hi0 += int'(fan_pwm_o[0]);
      hi1 += int'(fan_pwm_o[1]);
    end
    chk("pwm_hi8", hi0, 16);
    chk("pwm_hi0", hi1, 0);
    chk("stall_d0", stall_o[1], 1'b0);
    wait_to(320); chk("hold_8", cur_duty_o, 8'h08);

    // full duty -> constant high
    duty_i = 8'h0F;
    wait_to(543); chk("ramp_543", cur_duty_o, 8'h0E);
    wait_to(544); chk("ramp_544", cur_duty_o, 8'h0F);
    hi0 = 0;
    for (int i = 0; i < 32; i++) begin
      tick1();
      hi0 += int'(fan_pwm_o[0]);
    end
    chk("pwm_hi15", hi0, 32);

    // ramp both to 3, then force pulse
    duty_i = 8'h33;
    wait_to(608); chk("ramp_608", cur_duty_o, 8'h1E);
    wait_to(960); chk("ramp_960", cur_duty_o, 8'h33);
    force_full_i = 1'b1;
    wait_to(961);
    chk("force_duty", cur_duty_o, 8'hFF);
    chk("force_pwm", fan_pwm_o, 2'b11);
    force_full_i = 1'b0;
    wait_to(991);  chk("rel_991", cur_duty_o, 8'hFF);
    wait_to(992);  chk("rel_992", cur_duty_o, 8'hEE);
    wait_to(1024); chk("rel_1024", cur_duty_o, 8'hDD);
    wait_to(1344); chk("rel_1344", cur_duty_o, 8'h33);

    // three edges on ch1 in window ending 1360
    pulse(1344); pulse(1348); pulse(1352);
    wait_to(1359); chk("val_pre", tach_valid_o, 1'b0);
    wait_to(1360);
    chk("val_1360", tach_valid_o, 1'b1);
    chk("tcnt_1360", tach_cnt_o, 32'h0003_0000);
    chk("stall_1360", stall_o, 2'b01);
    wait_to(1361); chk("val_post", tach_valid_o, 1'b0);
    wait_to(1376);
    chk("tcnt_1376", tach_cnt_o, 32'h0);
    chk("stall_1376", stall_o, 2'b11);

    // edge landing on the window-end cycle
    pulse(1380);
    wait_to(1389); tach_i[1] = 1'b1;
    wait_to(1391); tach_i[1] = 1'b0;
    wait_to(1392);
    chk("tcnt_end", tach_cnt_o, 32'h0002_0000);
    chk("stall_end", stall_o, 2'b01);

    // saturation on narrow instance, two edges on main
    for (int t = 1408; t < 1424; t++) begin
      wait_to(t);
      if (t == 1408) begin
        chk("tcnt_once", tach_cnt_o, 32'h0);
        chk("stall_1408", stall_o, 2'b11);
      end
      tach_s[0] = ~tach_s[0];
      tach_i[1] = (t == 1408 || t == 1409 ||
                   t == 1412 || t == 1413);
    end
    wait_to(1424);
    tach_s = 2'b00;
    tach_i = 2'b00;
    chk("sat_cnt", s_cnt, 4'h3);
    chk("sat_valid", s_valid, 1'b1);
    chk("tcnt_1424", tach_cnt_o, 32'h0002_0000);

    // disable mid-window, force ignored
    wait_to(1429);
    en_i = 1'b0;
    force_full_i = 1'b1;
    wait_to(1430);
    chk("dis_duty", cur_duty_o, 8'h00);
    chk("dis_pwm", fan_pwm_o, 2'b00);
    chk("dis_stall", stall_o, 2'b00);
    chk("dis_valid", tach_valid_o, 1'b0);
    chk("dis_tcnt", tach_cnt_o, 32'h0002_0000);
    wait_to(1440);
    chk("dis_duty2", cur_duty_o, 8'h00);
    chk("dis_tcnt2", tach_cnt_o, 32'h0002_0000);
    en_i = 1'b1;
    force_full_i = 1'b0;

    // restart, then async reset mid-ramp
    pulse(1456);
    wait_to(1471); chk("re_1471", cur_duty_o, 8'h00);
    wait_to(1472);
    chk("re_1472", cur_duty_o, 8'h11);
    chk("re_tcnt", tach_cnt_o, 32'h0001_0000);
    chk("re_valid", tach_valid_o, 1'b1);
    wait_to(1480);
    rst_n = 1'b0;
    #1;
    chk("ar_duty", cur_duty_o, 8'h00);
    chk("ar_pwm", fan_pwm_o, 2'b00);
    chk("ar_tcnt", tach_cnt_o, 32'h0);
    chk("ar_valid", tach_valid_o, 1'b0);
    chk("ar_stall", stall_o, 2'b00);
    chk("ar_sat", s_cnt, 4'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
